rx_addr_filter: RTL and testbench



---
 rtl/rx_addr_filter_if.sv | 41 ++++
 rtl/rx_addr_filter.sv | 168 ++++++++++++++++
 tb/tb_rx_addr_filter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_addr_filter_if.sv
// Receive-stream, table-load, mode and decision signals of the destination-address filter.
// The block consumes the slave modport; the driving side uses master.
interface rx_addr_filter_if #(
    parameter int unsigned NENT = 14,
    parameter int unsigned CNTW = 16
);
    logic            frm_act_i;
    logic            byte_vld_i;
    logic [7:0]      rxd_i;
    logic            tbl_we_i;
    logic [3:0]      tbl_idx_i;
    logic [2:0]      tbl_byte_i;
    logic [7:0]      tbl_dat_i;
    logic [NENT-1:0] tbl_en_i;
    logic            promisc_i;
    logic            allmc_i;
    logic            cnt_clr_i;
    logic            dec_vld_o;
    logic            dec_acc_o;
    logic            dec_hit_o;
    logic [3:0]      dec_idx_o;
    logic            dec_mc_o;
    logic            dec_runt_o;
    logic [CNTW-1:0] rej_cnt_o;

    modport master (
        output frm_act_i, byte_vld_i, rxd_i,
        output tbl_we_i, tbl_idx_i, tbl_byte_i, tbl_dat_i, tbl_en_i,
        output promisc_i, allmc_i, cnt_clr_i,
        input  dec_vld_o, dec_acc_o, dec_hit_o, dec_idx_o, dec_mc_o, dec_runt_o,
        input  rej_cnt_o
    );

    modport slave (
        input  frm_act_i, byte_vld_i, rxd_i,
        input  tbl_we_i, tbl_idx_i, tbl_byte_i, tbl_dat_i, tbl_en_i,
        input  promisc_i, allmc_i, cnt_clr_i,
        output dec_vld_o, dec_acc_o, dec_hit_o, dec_idx_o, dec_mc_o, dec_runt_o,
        output rej_cnt_o
    );
endinterface

// File: rtl/rx_addr_filter.sv
// Receive destination-address filter: byte-serial DA compare against an address table,
// one accept/reject decision per frame and a saturating rejected-frame counter.
module rx_addr_filter #(
    parameter int unsigned NENT = 14,
    parameter int unsigned CNTW = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    rx_addr_filter_if.slave  bus
);
    localparam int unsigned DA_BYTES  = 6;
    localparam logic [2:0]  LAST_BYTE = 3'(DA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, DA, WAIT} state_t;

    state_t          state_q, state_nxt;
    logic            frm_act_q;
    logic            frm_rise;
    logic [NENT-1:0] match_q, match_nxt, match_base, match_fin, eq;
    logic [2:0]      cnt_q, cnt_nxt, cnt_base;
    logic            mc_q, mc_nxt;
    logic [3:0]      low_idx;
    logic [7:0]      tbl_q [NENT][DA_BYTES];

    logic            dec_vld_q, dec_vld_nxt;
    logic            dec_acc_q, dec_acc_nxt;
    logic            dec_hit_q, dec_hit_nxt;
    logic [3:0]      dec_idx_q, dec_idx_nxt;
    logic            dec_mc_q, dec_mc_nxt;
    logic            dec_runt_q, dec_runt_nxt;
    logic [CNTW-1:0] rej_q;

    assign frm_rise   = bus.frm_act_i & ~frm_act_q;
    // In IDLE the frame-start byte compares against a freshly seeded match vector.
    assign cnt_base   = (state_q == IDLE) ? 3'd0 : cnt_q;
    assign match_base = (state_q == IDLE) ? bus.tbl_en_i : match_q;

    // Parallel byte compare, then lowest-index priority encode of the surviving entries.
    always_comb begin
        eq = '0;
        for (int e = 0; e < int'(NENT); e++) begin
            eq[e] = (bus.rxd_i == tbl_q[e][cnt_base]);
        end
        match_fin = match_base & eq;
        low_idx   = '0;
        for (int i = int'(NENT) - 1; i >= 0; i--) begin
            if (match_fin[i]) low_idx = 4'(i);
        end
    end

    // Next-state and decision logic.
    always_comb begin
        state_nxt    = state_q;
        match_nxt    = match_q;
        cnt_nxt      = cnt_q;
        mc_nxt       = mc_q;
        dec_vld_nxt  = 1'b0;
        dec_acc_nxt  = dec_acc_q;
        dec_hit_nxt  = dec_hit_q;
        dec_idx_nxt  = dec_idx_q;
        dec_mc_nxt   = dec_mc_q;
        dec_runt_nxt = dec_runt_q;
        unique case (state_q)
            IDLE: begin
                if (frm_rise) begin
                    state_nxt = DA;
                    match_nxt = bus.tbl_en_i;
                    cnt_nxt   = 3'd0;
                    mc_nxt    = 1'b0;
                    if (bus.byte_vld_i) begin
                        match_nxt = match_fin;
                        mc_nxt    = bus.rxd_i[0];
                        cnt_nxt   = 3'd1;
                    end
                end
            end
            DA: begin
                if (!bus.frm_act_i) begin
                    state_nxt    = IDLE;
                    dec_vld_nxt  = 1'b1;
                    dec_acc_nxt  = bus.promisc_i;
                    dec_hit_nxt  = 1'b0;
                    dec_idx_nxt  = '0;
                    dec_mc_nxt   = mc_q;
                    dec_runt_nxt = 1'b1;
                end else if (bus.byte_vld_i) begin
                    match_nxt = match_fin;
                    cnt_nxt   = cnt_q + 3'd1;
                    if (cnt_q == 3'd0) mc_nxt = bus.rxd_i[0];
                    if (cnt_q == LAST_BYTE) begin
                        state_nxt    = WAIT;
                        dec_vld_nxt  = 1'b1;
                        dec_hit_nxt  = |match_fin;
                        dec_idx_nxt  = low_idx;
                        dec_mc_nxt   = mc_q;
                        dec_runt_nxt = 1'b0;
                        dec_acc_nxt  = bus.promisc_i | (|match_fin) | (bus.allmc_i & mc_q);
                    end
                end
            end
            WAIT: begin
                if (!bus.frm_act_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            frm_act_q  <= 1'b0;
            match_q    <= '0;
            cnt_q      <= '0;
            mc_q       <= 1'b0;
            dec_vld_q  <= 1'b0;
            dec_acc_q  <= 1'b0;
            dec_hit_q  <= 1'b0;
            dec_idx_q  <= '0;
            dec_mc_q   <= 1'b0;
            dec_runt_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            frm_act_q  <= bus.frm_act_i;
            match_q    <= match_nxt;
            cnt_q      <= cnt_nxt;
            mc_q       <= mc_nxt;
            dec_vld_q  <= dec_vld_nxt;
            dec_acc_q  <= dec_acc_nxt;
            dec_hit_q  <= dec_hit_nxt;
            dec_idx_q  <= dec_idx_nxt;
            dec_mc_q   <= dec_mc_nxt;
            dec_runt_q <= dec_runt_nxt;
        end
    end

    // Address table; out-of-range entry or byte indices are dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int e = 0; e < int'(NENT); e++) begin
                for (int b = 0; b < int'(DA_BYTES); b++) begin
                    tbl_q[e][b] <= '0;
                end
            end
        end else if (bus.tbl_we_i && ({1'b0, bus.tbl_idx_i} < 5'(NENT)) &&
                     (bus.tbl_byte_i < 3'(DA_BYTES))) begin
            tbl_q[bus.tbl_idx_i][bus.tbl_byte_i] <= bus.tbl_dat_i;
        end
    end

    // Saturating reject counter; clear wins over a coincident increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rej_q <= '0;
        end else if (bus.cnt_clr_i) begin
            rej_q <= '0;
        end else if (dec_vld_q && !dec_acc_q && !(&rej_q)) begin
            rej_q <= rej_q + CNTW'(1);
        end
    end

    assign bus.dec_vld_o  = dec_vld_q;
    assign bus.dec_acc_o  = dec_acc_q;
    assign bus.dec_hit_o  = dec_hit_q;
    assign bus.dec_idx_o  = dec_idx_q;
    assign bus.dec_mc_o   = dec_mc_q;
    assign bus.dec_runt_o = dec_runt_q;
    assign bus.rej_cnt_o  = rej_q;
endmodule

// File: tb/tb_rx_addr_filter.sv
// Directed bench for rx_addr_filter; an 8-bit reject counter keeps the saturation case short.
module tb_rx_addr_filter;
    localparam int unsigned NENT = 14;
    localparam int unsigned CNTW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rx_addr_filter_if #(.NENT(NENT), .CNTW(CNTW)) bus ();

    rx_addr_filter #(.NENT(NENT), .CNTW(CNTW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dec(input string tag, input logic acc, input logic hit,
                           input logic [3:0] idx, input logic mc, input logic runt);
        chk({tag, "_vld"},  32'(bus.dec_vld_o), 32'd1);
        chk({tag, "_acc"},  32'(bus.dec_acc_o), 32'(acc));
        chk({tag, "_hit"},  32'(bus.dec_hit_o), 32'(hit));
        chk({tag, "_idx"},  32'(bus.dec_idx_o), 32'(idx));
        chk({tag, "_mc"},   32'(bus.dec_mc_o),  32'(mc));
        chk({tag, "_runt"}, 32'(bus.dec_runt_o), 32'(runt));
    endtask

    task automatic wr_tbl(input logic [3:0] idx, input logic [47:0] mac);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            bus.tbl_we_i   = 1'b1;
            bus.tbl_idx_i  = idx;
            bus.tbl_byte_i = 3'(b);
            bus.tbl_dat_i  = mac[47 - 8*b -: 8];
        end
        @(negedge clk);
        bus.tbl_we_i = 1'b0;
    endtask

    // Byte 0 is driven together with the frm_act rising edge.
    task automatic send_da(input logic [47:0] mac, input int n);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            bus.frm_act_i  = 1'b1;
            bus.byte_vld_i = 1'b1;
            bus.rxd_i      = mac[47 - 8*b -: 8];
        end
    endtask

    // Returns on the cycle the decision strobe is expected.
    task automatic full_frame(input string tag, input logic [47:0] mac);
        send_da(mac, 6);
        chk({tag, "_early"}, 32'(bus.dec_vld_o), 32'd0);
        @(negedge clk);
        bus.byte_vld_i = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        @(negedge clk);
        chk({tag, "_strobe1"}, 32'(bus.dec_vld_o), 32'd0);
        bus.frm_act_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic runt_frame(input logic [47:0] mac, input int n);
        send_da(mac, n);
        @(negedge clk);
        bus.byte_vld_i = 1'b0;
        bus.frm_act_i  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.frm_act_i  = 1'b0;
        bus.byte_vld_i = 1'b0;
        bus.rxd_i      = '0;
        bus.tbl_we_i   = 1'b0;
        bus.tbl_idx_i  = '0;
        bus.tbl_byte_i = '0;
        bus.tbl_dat_i  = '0;
        bus.tbl_en_i   = '0;
        bus.promisc_i  = 1'b0;
        bus.allmc_i    = 1'b0;
        bus.cnt_clr_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(bus.dec_vld_o), 32'd0);
        chk("rst_acc", 32'(bus.dec_acc_o), 32'd0);
        chk("rst_idx", 32'(bus.dec_idx_o), 32'd0);
        chk("rst_rej", 32'(bus.rej_cnt_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Station address hit on entry 3
        wr_tbl(4'd3, 48'h08002B112233);
        bus.tbl_en_i = 14'(1 << 3);
        full_frame("stn", 48'h08002B112233);
        chk_dec("stn", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        end_frame("stn");
        chk("stn_hold_acc", 32'(bus.dec_acc_o), 32'd1);
        chk("stn_hold_idx", 32'(bus.dec_idx_o), 32'd3);

        // Broadcast in entries 2 and 9: lowest enabled wins
        wr_tbl(4'd2, 48'hFFFFFFFFFFFF);
        wr_tbl(4'd9, 48'hFFFFFFFFFFFF);
        bus.tbl_en_i = 14'((1 << 2) | (1 << 3) | (1 << 9));
        full_frame("bc2", 48'hFFFFFFFFFFFF);
        chk_dec("bc2", 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
        end_frame("bc2");
        bus.tbl_en_i = 14'((1 << 3) | (1 << 9));
        full_frame("bc9", 48'hFFFFFFFFFFFF);
        chk_dec("bc9", 1'b1, 1'b1, 4'd9, 1'b1, 1'b0);
        end_frame("bc9");

        // Multicast without table match
        full_frame("mc0", 48'h01005E000001);
        chk_dec("mc0", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        end_frame("mc0");
        chk("mc0_rej", 32'(bus.rej_cnt_o), 32'd1);
        bus.allmc_i = 1'b1;
        full_frame("mc1", 48'h01005E000001);
        chk_dec("mc1", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        end_frame("mc1");
        chk("mc1_rej", 32'(bus.rej_cnt_o), 32'd1);
        bus.allmc_i = 1'b0;

        // Runt frames
        runt_frame(48'h08002B112233, 4);
        chk_dec("runt0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("runt0_rej", 32'(bus.rej_cnt_o), 32'd2);
        bus.promisc_i = 1'b1;
        runt_frame(48'h08002B112233, 4);
        chk_dec("runt1", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("runt1_rej", 32'(bus.rej_cnt_o), 32'd2);
        bus.promisc_i = 1'b0;

        // Drive the counter to all-ones with back-to-back empty frames
        for (int i = 0; i < 253; i++) begin
            @(negedge clk);
            bus.frm_act_i = 1'b1;
            @(negedge clk);
            bus.frm_act_i = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("sat_full", 32'(bus.rej_cnt_o), 32'hFF);
        @(negedge clk);
        bus.frm_act_i = 1'b1;
        @(negedge clk);
        bus.frm_act_i = 1'b0;
        @(negedge clk);
        chk("sat_rej_vld", 32'(bus.dec_vld_o), 32'd1);
        @(negedge clk);
        chk("sat_hold", 32'(bus.rej_cnt_o), 32'hFF);

        // Clear coincident with a reject strobe
        bus.frm_act_i = 1'b1;
        @(negedge clk);
        bus.frm_act_i = 1'b0;
        @(negedge clk);
        chk("clr_vld", 32'(bus.dec_vld_o), 32'd1);
        chk("clr_acc", 32'(bus.dec_acc_o), 32'd0);
        bus.cnt_clr_i = 1'b1;
        @(negedge clk);
        bus.cnt_clr_i = 1'b0;
        chk("clr_rej", 32'(bus.rej_cnt_o), 32'd0);
        runt_frame(48'h08002B112233, 2);
        @(negedge clk);
        chk("post_clr_rej", 32'(bus.rej_cnt_o), 32'd1);

        // Asynchronous reset at the third DA byte
        bus.tbl_en_i = 14'(1 << 3);
        send_da(48'h08002B112233, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_runt", 32'(bus.dec_runt_o), 32'd0);
        chk("arst_rej",  32'(bus.rej_cnt_o), 32'd0);
        chk("arst_vld",  32'(bus.dec_vld_o), 32'd0);
        @(negedge clk);
        bus.frm_act_i  = 1'b0;
        bus.byte_vld_i = 1'b0;
        @(negedge clk);
        chk("arst_novld", 32'(bus.dec_vld_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_vld", 32'(bus.dec_vld_o), 32'd0);

        // Table now zero: the old station address misses, an all-zero DA hits entry 3
        full_frame("post_stn", 48'h08002B112233);
        chk_dec("post_stn", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end_frame("post_stn");
        chk("post_stn_rej", 32'(bus.rej_cnt_o), 32'd1);
        full_frame("post_zero", 48'h000000000000);
        chk_dec("post_zero", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
        end_frame("post_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
